// File: rtl/io_uart.sv
// io_uart: byte I/O peripheral behind the core's OP_IN/OP_OUT instructions.
// TX/RX FIFOs with valid/ready core ports and an 8N1 serializer/deserializer.
module io_uart #(
   parameter int CLK_PER_BIT = 868,
   parameter int TX_DEPTH    = 16,
   parameter int RX_DEPTH    = 16
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       OUT_VALID,
   input  logic [7:0] OUT_DATA,
   output logic       OUT_READY,
   output logic       IN_VALID,
   output logic [7:0] IN_DATA,
   input  logic       IN_READY,
   input  logic       ERR_CLR,
   output logic       FRAME_ERR,
   output logic       OVERRUN,
   input  logic       RXD,
   output logic       TXD
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int CW  = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]   tx_mem [TX_DEPTH];
   logic [TAW:0] tx_wr;
   logic [TAW:0] tx_rd;
   logic         tx_full;
   logic         tx_empty;
   logic         tx_push;
   logic         tx_pop;
   logic [7:0]   tx_head;

   state_t       tx_state;
   state_t       tx_state_n;
   logic [CW-1:0] tx_cnt;
   logic [CW-1:0] tx_cnt_n;
   logic [2:0]   tx_bit;
   logic [2:0]   tx_bit_n;
   logic [7:0]   tx_sh;
   logic [7:0]   tx_sh_n;
   logic         txd_n;

   assign tx_full  = (tx_wr[TAW] != tx_rd[TAW]) &&
                     (tx_wr[TAW-1:0] == tx_rd[TAW-1:0]);
   assign tx_empty = (tx_wr == tx_rd);
   assign tx_push  = OUT_VALID & OUT_READY;
   assign tx_head  = tx_mem[tx_rd[TAW-1:0]];
   assign OUT_READY = !tx_full;

   always_ff @(posedge CLK) begin
      if (tx_push) tx_mem[tx_wr[TAW-1:0]] <= OUT_DATA;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tx_wr    <= '0;
         tx_rd    <= '0;
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         TXD      <= 1'b1;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_pop)  tx_rd <= tx_rd + 1'b1;
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_sh    <= tx_sh_n;
         TXD      <= txd_n;
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_sh_n    = tx_sh;
      tx_pop     = 1'b0;
      unique case (tx_state)
         IDLE: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_sh_n    = tx_head;
               tx_cnt_n   = BIT_LAST;
               tx_state_n = START;
            end
         end
         START: begin
            if (tx_cnt == '0) begin
               tx_cnt_n   = BIT_LAST;
               tx_bit_n   = '0;
               tx_state_n = DATA;
            end else begin
               tx_cnt_n = tx_cnt - 1'b1;
            end
         end
         DATA: begin
            if (tx_cnt == '0) begin
               tx_cnt_n = BIT_LAST;
               tx_sh_n  = {1'b0, tx_sh[7:1]};
               if (tx_bit == 3'd7) tx_state_n = STOP;
               else tx_bit_n = tx_bit + 3'd1;
            end else begin
               tx_cnt_n = tx_cnt - 1'b1;
            end
         end
         STOP: begin
            if (tx_cnt == '0) begin
               // back-to-back frames: reload straight into START, no idle bit
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_sh_n    = tx_head;
                  tx_cnt_n   = BIT_LAST;
                  tx_state_n = START;
               end else begin
                  tx_state_n = IDLE;
               end
            end else begin
               tx_cnt_n = tx_cnt - 1'b1;
            end
         end
         default: tx_state_n = IDLE;
      endcase
   end

   always_comb begin
      txd_n = 1'b1;
      unique case (tx_state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = tx_sh_n[0];
         default: txd_n = 1'b1;
      endcase
   end

   logic [1:0]   rx_sync;
   logic         rxs;
   state_t       rx_state;
   state_t       rx_state_n;
   logic [CW-1:0] rx_cnt;
   logic [CW-1:0] rx_cnt_n;
   logic [2:0]   rx_bit;
   logic [2:0]   rx_bit_n;
   logic [7:0]   rx_sh;
   logic [7:0]   rx_sh_n;
   logic         rx_armed;
   logic         rx_armed_n;
   logic         stop_ok;
   logic         stop_bad;

   assign rxs = rx_sync[1];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_sync  <= 2'b11;
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         rx_armed <= 1'b0;
      end else begin
         rx_sync  <= {rx_sync[0], RXD};
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
         rx_armed <= rx_armed_n;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bit_n   = rx_bit;
      rx_sh_n    = rx_sh;
      rx_armed_n = rx_armed;
      stop_ok    = 1'b0;
      stop_bad   = 1'b0;
      unique case (rx_state)
         IDLE: begin
            // a line held low after a bad stop must go high before re-arming
            if (!rx_armed) begin
               if (rxs) rx_armed_n = 1'b1;
            end else if (!rxs) begin
               rx_cnt_n   = HALF_LAST;
               rx_state_n = START;
            end
         end
         START: begin
            if (rx_cnt == '0) begin
               if (!rxs) begin
                  rx_cnt_n   = BIT_LAST;
                  rx_bit_n   = '0;
                  rx_state_n = DATA;
               end else begin
                  rx_state_n = IDLE;
               end
            end else begin
               rx_cnt_n = rx_cnt - 1'b1;
            end
         end
         DATA: begin
            if (rx_cnt == '0) begin
               rx_cnt_n = BIT_LAST;
               rx_sh_n  = {rxs, rx_sh[7:1]};
               if (rx_bit == 3'd7) rx_state_n = STOP;
               else rx_bit_n = rx_bit + 3'd1;
            end else begin
               rx_cnt_n = rx_cnt - 1'b1;
            end
         end
         STOP: begin
            if (rx_cnt == '0) begin
               stop_ok    = rxs;
               stop_bad   = !rxs;
               rx_armed_n = 1'b0;
               rx_state_n = IDLE;
            end else begin
               rx_cnt_n = rx_cnt - 1'b1;
            end
         end
         default: rx_state_n = IDLE;
      endcase
   end

   logic [7:0]   rx_mem [RX_DEPTH];
   logic [RAW:0] rx_wr;
   logic [RAW:0] rx_rd;
   logic [RAW:0] rx_wr_n;
   logic [RAW:0] rx_rd_n;
   logic         rx_full;
   logic         rx_push;
   logic         rx_pop;
   logic         ovr_set;

   assign rx_full = (rx_wr[RAW] != rx_rd[RAW]) &&
                    (rx_wr[RAW-1:0] == rx_rd[RAW-1:0]);
   assign rx_pop  = IN_VALID & IN_READY;
   assign rx_push = stop_ok & (!rx_full | rx_pop);
   assign ovr_set = stop_ok & rx_full & !rx_pop;
   assign rx_wr_n = rx_wr + {{RAW{1'b0}}, rx_push};
   assign rx_rd_n = rx_rd + {{RAW{1'b0}}, rx_pop};

   always_ff @(posedge CLK) begin
      if (rx_push) rx_mem[rx_wr[RAW-1:0]] <= rx_sh;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_wr     <= '0;
         rx_rd     <= '0;
         IN_VALID  <= 1'b0;
         IN_DATA   <= '0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         rx_wr    <= rx_wr_n;
         rx_rd    <= rx_rd_n;
         IN_VALID <= (rx_wr_n != rx_rd_n);
         // next head is either the byte landing this edge or a stored one
         if (rx_wr_n != rx_rd_n)
            IN_DATA <= (rx_rd_n == rx_wr) ? rx_sh : rx_mem[rx_rd_n[RAW-1:0]];
         if (stop_bad) FRAME_ERR <= 1'b1;
         else if (ERR_CLR) FRAME_ERR <= 1'b0;
         if (ovr_set) OVERRUN <= 1'b1;
         else if (ERR_CLR) OVERRUN <= 1'b0;
      end
   end

endmodule
